// File: rtl/ariane_axi_soc.sv
// SoC-level AXI4-Lite channel and bundle typedefs used by the configuration slaves.
package ariane_axi_soc;

  localparam int unsigned LiteAddrWidth = 32;
  localparam int unsigned LiteDataWidth = 32;
  localparam int unsigned LiteStrbWidth = LiteDataWidth / 8;

  typedef logic [LiteAddrWidth-1:0] addr_lite_t;
  typedef logic [LiteDataWidth-1:0] data_lite_t;
  typedef logic [LiteStrbWidth-1:0] strb_lite_t;

  typedef struct packed {
    addr_lite_t      addr;
    axi_pkg::prot_t  prot;
  } aw_chan_lite_t;

  typedef struct packed {
    data_lite_t data;
    strb_lite_t strb;
  } w_chan_lite_t;

  typedef struct packed {
    axi_pkg::resp_t resp;
  } b_chan_lite_t;

  typedef struct packed {
    addr_lite_t      addr;
    axi_pkg::prot_t  prot;
  } ar_chan_lite_t;

  typedef struct packed {
    data_lite_t     data;
    axi_pkg::resp_t resp;
  } r_chan_lite_t;

  typedef struct packed {
    aw_chan_lite_t aw;
    logic          aw_valid;
    w_chan_lite_t  w;
    logic          w_valid;
    logic          b_ready;
    ar_chan_lite_t ar;
    logic          ar_valid;
    logic          r_ready;
  } req_lite_t;

  typedef struct packed {
    logic          aw_ready;
    logic          w_ready;
    b_chan_lite_t  b;
    logic          b_valid;
    logic          ar_ready;
    r_chan_lite_t  r;
    logic          r_valid;
  } resp_lite_t;

endpackage

// File: rtl/axi_pkg.sv
// AXI protocol constants shared across the SoC.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [2:0] prot_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/cfg_lite_regbank_decode.sv
// Combinational address decode for the register bank: word index relative to base,
// range check (modular, so addresses below base wrap to huge indices), read-only and lock flags.
module cfg_lite_regbank_decode #(
  parameter int unsigned        NumRegs      = 8,
  parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
  parameter int unsigned        IdxW         = 3
) (
  input  logic [31:0]     addr,
  input  logic [31:0]     base_addr,
  input  logic            lock,
  output logic [IdxW-1:0] idx_c,
  output logic            in_range_c,
  output logic            ro_c,
  output logic            locked_c
);

  localparam int unsigned MaskW = 1 << IdxW;

  logic [31:0]      offset;
  logic [31:0]      word;
  logic [MaskW-1:0] mask_ext;

  assign offset     = addr - base_addr;
  assign word       = offset >> 2;
  assign mask_ext   = MaskW'(ReadOnlyMask);
  assign in_range_c = (word < 32'(NumRegs));
  assign idx_c      = word[IdxW-1:0];
  assign ro_c       = in_range_c & mask_ext[idx_c];
  assign locked_c   = lock;

endmodule

// File: rtl/cfg_lite_regbank.sv
// AXI4-Lite slave exposing NumRegs 32-bit registers with one outstanding transaction.
// Optional CFG_REGBANK_LOCK_EN: bit 0 of the last register becomes a sticky write lock.
module cfg_lite_regbank
  import ariane_axi_soc::*;
#(
  parameter int unsigned            NumRegs      = 8,
  parameter logic [NumRegs-1:0]     ReadOnlyMask = '0,
  parameter logic [NumRegs*32-1:0]  ResetVal     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  req_lite_t               slv_req_i,
  output resp_lite_t              slv_resp_o,
  input  logic [31:0]             base_addr_i,
  output logic [NumRegs*32-1:0]   reg_q_o,
  output logic [NumRegs-1:0]      reg_wr_o,
  input  logic [NumRegs*32-1:0]   hw_d_i
);

  localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRESP = 2'd1,
    RRESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [NumRegs-1:0][31:0]   regs_q;
  logic [NumRegs-1:0][31:0]   hw_d;
  logic [NumRegs-1:0]         reg_wr_q;
  axi_pkg::resp_t             b_resp_q, r_resp_q;
  logic [31:0]                r_data_q;

  logic                       aw_ready_c, ar_ready_c, wr_en_c, rd_en_c, wr_ok_c;
  logic [31:0]                rd_data_c;
  axi_pkg::resp_t             rd_resp_c;
  logic                       lock;

  logic [IdxW-1:0]            w_idx, r_idx;
  logic                       w_in_range, w_ro, w_locked;
  logic                       r_in_range, r_ro;
  logic                       unused_r_locked;
  logic                       unused_prot;

  assign hw_d        = hw_d_i;
  assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

`ifdef CFG_REGBANK_LOCK_EN
  // Once set, every write is refused, so the bit can only be cleared by reset.
  assign lock = regs_q[NumRegs-1][0];
`else
  assign lock = 1'b0;
`endif

  cfg_lite_regbank_decode #(
    .NumRegs      (NumRegs),
    .ReadOnlyMask (ReadOnlyMask),
    .IdxW         (IdxW)
  ) u_wr_decode (
    .addr       (slv_req_i.aw.addr),
    .base_addr  (base_addr_i),
    .lock       (lock),
    .idx_c      (w_idx),
    .in_range_c (w_in_range),
    .ro_c       (w_ro),
    .locked_c   (w_locked)
  );

  cfg_lite_regbank_decode #(
    .NumRegs      (NumRegs),
    .ReadOnlyMask (ReadOnlyMask),
    .IdxW         (IdxW)
  ) u_rd_decode (
    .addr       (slv_req_i.ar.addr),
    .base_addr  (base_addr_i),
    .lock       (lock),
    .idx_c      (r_idx),
    .in_range_c (r_in_range),
    .ro_c       (r_ro),
    .locked_c   (unused_r_locked)
  );

  assign wr_ok_c = wr_en_c & w_in_range & ~w_ro & ~w_locked;

  // Read data source: hardware value for read-only slots, zero when out of range.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = axi_pkg::RESP_SLVERR;
    if (r_in_range) begin
      rd_resp_c = axi_pkg::RESP_OKAY;
      rd_data_c = r_ro ? hw_d[r_idx] : regs_q[r_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Write wins over a simultaneous read; readies stay low while a response is pending.
  always_comb begin
    state_d    = state_q;
    aw_ready_c = 1'b0;
    ar_ready_c = 1'b0;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_ni && slv_req_i.aw_valid && slv_req_i.w_valid) begin
          aw_ready_c = 1'b1;
          wr_en_c    = 1'b1;
          state_d    = WRESP;
        end else if (rst_ni && slv_req_i.ar_valid) begin
          ar_ready_c = 1'b1;
          rd_en_c    = 1'b1;
          state_d    = RRESP;
        end
      end
      WRESP:   if (slv_req_i.b_ready) state_d = IDLE;
      RRESP:   if (slv_req_i.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= ResetVal;
    end else if (wr_ok_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (slv_req_i.w.strb[b]) regs_q[w_idx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_wr_q <= '0;
      b_resp_q <= axi_pkg::RESP_OKAY;
      r_resp_q <= axi_pkg::RESP_OKAY;
      r_data_q <= '0;
    end else begin
      reg_wr_q <= '0;
      if (wr_ok_c) reg_wr_q[w_idx] <= 1'b1;
      if (wr_en_c) b_resp_q <= wr_ok_c ? axi_pkg::RESP_OKAY : axi_pkg::RESP_SLVERR;
      if (rd_en_c) begin
        r_data_q <= rd_data_c;
        r_resp_q <= rd_resp_c;
      end
    end
  end

  assign reg_q_o  = regs_q;
  assign reg_wr_o = reg_wr_q;

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_c;
    slv_resp_o.w_ready  = aw_ready_c;
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.b_valid  = (state_q == WRESP);
    slv_resp_o.ar_ready = ar_ready_c;
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
    slv_resp_o.r_valid  = (state_q == RRESP);
  end

endmodule

// File: tb/tb_cfg_lite_regbank.sv
// Scoreboard bench for cfg_lite_regbank: B/R expectations queued at issue, checked on handshake.
// Define CFG_REGBANK_LOCK_EN for both RTL and bench to exercise the sticky lock.
module tb_cfg_lite_regbank;
  import ariane_axi_soc::*;

  localparam int unsigned NUM_REGS = 8;
  localparam logic [31:0] BASE = 32'h1040_0000;
  localparam logic [NUM_REGS-1:0] RO_MASK = 8'b0000_0010;
  localparam logic [NUM_REGS*32-1:0] RESET_VAL = {32'h0, 32'h0, 32'h0, 32'h0,
                                                  32'hA5A5_0003, 32'h0, 32'h0000_BEEF, 32'h0};
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  req_lite_t req;
  resp_lite_t resp;
  logic [31:0] base;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0] reg_wr;
  logic [NUM_REGS*32-1:0] hw_d;

  exp_t bq[$];
  exp_t rq[$];
  exp_t mon_b, mon_r;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [NUM_REGS];

  always #5 clk = ~clk;

  cfg_lite_regbank #(
    .NumRegs      (NUM_REGS),
    .ReadOnlyMask (RO_MASK),
    .ResetVal     (RESET_VAL)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slv_req_i   (req),
    .slv_resp_o  (resp),
    .base_addr_i (base),
    .reg_q_o     (reg_q),
    .reg_wr_o    (reg_wr),
    .hw_d_i      (hw_d)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mdl_flat();
    logic [255:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = mdl[i];
    return f;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = RESET_VAL[i*32 +: 32];
  endtask

  // Response monitor: every B/R handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp.b_valid && req.b_ready) begin
        check_eq("b_expected", 256'(bq.size() != 0), 256'(1));
        if (bq.size() != 0) begin
          mon_b = bq.pop_front();
          check_eq("b_resp", 256'(resp.b.resp), 256'(mon_b.resp));
        end
      end
      if (resp.r_valid && req.r_ready) begin
        check_eq("r_expected", 256'(rq.size() != 0), 256'(1));
        if (rq.size() != 0) begin
          mon_r = rq.pop_front();
          check_eq("r_resp", 256'(resp.r.resp), 256'(mon_r.resp));
          check_eq("r_data", 256'(resp.r.data), 256'(mon_r.data));
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_aw_ready", 256'(resp.aw_ready), 256'(0));
    check_eq("rst_w_ready", 256'(resp.w_ready), 256'(0));
    check_eq("rst_ar_ready", 256'(resp.ar_ready), 256'(0));
    check_eq("rst_b_valid", 256'(resp.b_valid), 256'(0));
    check_eq("rst_r_valid", 256'(resp.r_valid), 256'(0));
    check_eq("rst_r_data", 256'(resp.r.data), 256'(0));
    check_eq("rst_b_resp", 256'(resp.b.resp), 256'(OKAY));
    check_eq("rst_r_resp", 256'(resp.r.resp), 256'(OKAY));
    check_eq("rst_reg_wr", 256'(reg_wr), 256'(0));
    check_eq("rst_reg_q", 256'(reg_q), 256'(RESET_VAL));
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int hold);
    int idx;
    bit hs;
    logic [NUM_REGS-1:0] pulse;
    idx = int'((addr - base) >> 2);
    pulse = '0;
    if (exp_resp == OKAY) begin
      pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end
    bq.push_back(exp_t'{resp: exp_resp, data: 32'h0});
    @(posedge clk); #1;
    if (hold > 0) req.b_ready = 1'b0;
    req.aw.addr = addr; req.aw.prot = '0;
    req.w.data = data; req.w.strb = strb;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = resp.aw_ready && resp.w_ready;
    end
    check_eq("aw_w_handshake", 256'(hs), 256'(1));
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    @(negedge clk);
    check_eq("b_valid_lat", 256'(resp.b_valid), 256'(1));
    check_eq("wr_pulse", 256'(reg_wr), 256'(pulse));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("b_hold_valid", 256'(resp.b_valid), 256'(1));
      check_eq("b_hold_resp", 256'(resp.b.resp), 256'(exp_resp));
      check_eq("hold_ready", 256'(resp.ar_ready), 256'(0));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req.b_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("b_drop", 256'(resp.b_valid), 256'(0));
    check_eq("wr_pulse_end", 256'(reg_wr), 256'(0));
    check_eq("regs", 256'(reg_q), mdl_flat());
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                          input int hold);
    bit hs;
    rq.push_back(exp_t'{resp: exp_resp, data: exp_data});
    @(posedge clk); #1;
    if (hold > 0) req.r_ready = 1'b0;
    req.ar.addr = addr; req.ar.prot = '0;
    req.ar_valid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = resp.ar_ready;
    end
    check_eq("ar_handshake", 256'(hs), 256'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    @(negedge clk);
    check_eq("r_valid_lat", 256'(resp.r_valid), 256'(1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("r_hold_valid", 256'(resp.r_valid), 256'(1));
      check_eq("r_hold_data", 256'(resp.r.data), 256'(exp_data));
      check_eq("r_hold_resp", 256'(resp.r.resp), 256'(exp_resp));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req.r_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("r_drop", 256'(resp.r_valid), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    req = '0;
    base = BASE;
    for (int i = 0; i < NUM_REGS; i++) hw_d[i*32 +: 32] = 32'hF0F0_0000 | 32'(i);
    hw_d[63:32] = 32'h0000_1234;
    mdl_reset();
    apply_reset();

    // Full-word write, partial strobe merge, empty strobe, unaligned address.
    axi_write(32'h1040_0008, 32'hDEAD_BEEF, 4'hF, OKAY, 0);
    check_eq("req032_reg2", 256'(reg_q[95:64]), 256'(32'hDEAD_BEEF));
    axi_write(32'h1040_0008, 32'h0000_5500, 4'h2, OKAY, 0);
    check_eq("req033_reg2", 256'(reg_q[95:64]), 256'(32'hDEAD_55EF));
    axi_write(32'h1040_0008, 32'hFFFF_FFFF, 4'h0, OKAY, 0);
    axi_write(32'h1040_0013, 32'h1122_3344, 4'hF, OKAY, 0);
    axi_read(32'h1040_0008, OKAY, 32'hDEAD_55EF, 0);
    axi_read(32'h1040_000C, OKAY, 32'hA5A5_0003, 0);
    axi_read(32'h1040_0010, OKAY, mdl[4], 0);

    // Reg 1 is read-only in this build, so move the base so 0x1040_0004 selects reg 3.
    base = 32'h103F_FFF8;
    mdl[3] = 32'hCAFE_F00D;
    bq.push_back(exp_t'{resp: OKAY, data: 32'h0});
    rq.push_back(exp_t'{resp: OKAY, data: 32'hCAFE_F00D});
    @(posedge clk); #1;
    req.aw.addr = 32'h1040_0004; req.w.data = 32'hCAFE_F00D; req.w.strb = 4'hF;
    req.ar.addr = 32'h1040_0004;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    @(negedge clk);
    check_eq("sim_aw_ready", 256'(resp.aw_ready), 256'(1));
    check_eq("sim_w_ready", 256'(resp.w_ready), 256'(1));
    check_eq("sim_ar_ready", 256'(resp.ar_ready), 256'(0));
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    @(negedge clk);
    check_eq("sim_b_valid", 256'(resp.b_valid), 256'(1));
    check_eq("sim_ar_wait", 256'(resp.ar_ready), 256'(0));
    check_eq("sim_pulse", 256'(reg_wr), 256'(8'h08));
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = resp.ar_ready;
    end
    check_eq("sim_ar_handshake", 256'(hs), 256'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    @(negedge clk);
    check_eq("sim_r_valid", 256'(resp.r_valid), 256'(1));
    @(negedge clk);
    check_eq("sim_regs", 256'(reg_q), mdl_flat());
    base = BASE;

    // Out of range above the bank and wrapped below the base; stalled B and R.
    axi_read(32'h1040_0020, SLVERR, 32'h0, 0);
    axi_read(32'h103F_FFFC, SLVERR, 32'h0, 3);
    axi_write(32'h1040_0020, 32'h5A5A_5A5A, 4'hF, SLVERR, 5);
    axi_write(32'h103F_FFFC, 32'h5A5A_5A5A, 4'hF, SLVERR, 0);

    // Read-only register: write refused, read returns the hardware value.
    axi_write(32'h1040_0004, 32'hFFFF_FFFF, 4'hF, SLVERR, 0);
    axi_read(32'h1040_0004, OKAY, 32'h0000_1234, 0);

`ifdef CFG_REGBANK_LOCK_EN
    axi_write(32'h1040_001C, 32'h0000_0001, 4'hF, OKAY, 0);
    axi_write(32'h1040_0000, 32'h55AA_55AA, 4'hF, SLVERR, 0);
    axi_read(32'h1040_0000, OKAY, mdl[0], 0);
    axi_write(32'h1040_001C, 32'h0000_0000, 4'hF, SLVERR, 0);
    axi_read(32'h1040_001C, OKAY, 32'h0000_0001, 0);
    apply_reset();
    axi_write(32'h1040_0000, 32'h55AA_55AA, 4'hF, OKAY, 0);
`else
    axi_write(32'h1040_001C, 32'h0000_0001, 4'hF, OKAY, 0);
    axi_write(32'h1040_0000, 32'h55AA_55AA, 4'hF, OKAY, 0);
    axi_write(32'h1040_001C, 32'h0000_0000, 4'hF, OKAY, 0);
    axi_read(32'h1040_001C, OKAY, 32'h0000_0000, 0);
`endif

    // Reset while a read response is stalled: the response must vanish for good.
    @(posedge clk); #1;
    req.r_ready = 1'b0;
    req.ar.addr = 32'h1040_0008;
    req.ar_valid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = resp.ar_ready;
    end
    check_eq("mid_ar_handshake", 256'(hs), 256'(1));
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_r_valid", 256'(resp.r_valid), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_r_drop", 256'(resp.r_valid), 256'(0));
    check_eq("mid_reg_q", 256'(reg_q), 256'(RESET_VAL));
    @(posedge clk); #1;
    rst_n = 1'b1;
    req.r_ready = 1'b1;
    mdl_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("mid_no_late_r", 256'(resp.r_valid), 256'(0));
    end
    axi_read(32'h1040_0008, OKAY, 32'h0, 0);

    repeat (3) @(negedge clk);
    check_eq("bq_drained", 256'(bq.size()), 256'(0));
    check_eq("rq_drained", 256'(rq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_lite_regbank.md
CFG_LITE_REGBANK -- requirements
Module: cfg_lite_regbank

Interface
REQ-001 SHALL have parameter NumRegs, default 8, giving the number of 32-bit registers (range 2..64).
REQ-002 SHALL have parameter ReadOnlyMask, default '0, NumRegs bits; bit i set makes register i read-only from the bus.
REQ-003 SHALL have parameter ResetVal, default '0, NumRegs*32 bits, giving the reset value of each register.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port slv_req_i, input, ariane_axi_soc::req_lite_t: AXI4-Lite request (AW, W, B-ready, AR, R-ready).
REQ-007 SHALL have port slv_resp_o, output, ariane_axi_soc::resp_lite_t: AXI4-Lite response.
REQ-008 SHALL have port base_addr_i, input, 32 bits: base address; quasi-static.
REQ-009 SHALL have port reg_q_o, output, NumRegs*32 bits: current register contents.
REQ-010 SHALL have port reg_wr_o, output, NumRegs bits: one-cycle pulse per register on a successful write.
REQ-011 SHALL have port hw_d_i, input, NumRegs*32 bits: value returned on reads of read-only registers.

Function
REQ-012 SHALL implement FSM states IDLE, WRESP, RRESP and allow at most one outstanding transaction.
REQ-013 In IDLE, SHALL assert aw_ready and w_ready together in the same cycle, only when aw_valid and w_valid are both high.
REQ-014 In IDLE, SHALL assert ar_ready only when no write is accepted that cycle, so a write wins a simultaneous AW+W/AR arrival.
REQ-015 On write handshake in cycle N, SHALL update the register in N, pulse reg_wr_o in N+1, assert b_valid from N+1 and enter WRESP.
REQ-016 On read handshake in cycle N, SHALL present r_valid and r_data from N+1 and enter RRESP.
REQ-017 SHALL hold b_valid/b_resp or r_valid/r_data/r_resp stable until the matching ready, then return to IDLE in the next cycle.
REQ-018 SHALL keep all ready outputs low in WRESP and RRESP.
REQ-019 SHALL compute index = (addr - base_addr_i) >> 2 in 32-bit modular arithmetic and ignore addr[1:0].
REQ-020 SHALL treat index >= NumRegs, including wrap-around below base, as out of range: SLVERR, no update, no pulse, r_data 0.
REQ-021 SHALL apply w_strb bytewise, so a strobe of 0 leaves the register unchanged but still returns OKAY and pulses.
REQ-022 SHALL answer a write to a read-only register with SLVERR and leave it unchanged.
REQ-023 SHALL answer a read of a read-only register with OKAY and the matching hw_d_i slice.
REQ-024 SHALL answer reads of read-write registers with OKAY and the register value.

Reset
REQ-025 While rst_ni is low, SHALL set FSM=IDLE, all valid/ready outputs 0, r_data 0, b_resp/r_resp OKAY, reg_wr_o 0, registers to ResetVal.
REQ-026 A reset asserted mid-transaction SHALL drop the pending response with no later B or R.

Configuration
REQ-027 With CFG_REGBANK_LOCK_EN defined, register NumRegs-1 bit 0 SHALL be a sticky lock: once written to 1, it stays set until reset.
REQ-028 With CFG_REGBANK_LOCK_EN defined and the lock set, writes to any register SHALL return SLVERR with no update and no pulse; reads are unaffected.
REQ-029 Without CFG_REGBANK_LOCK_EN, register NumRegs-1 SHALL be an ordinary register.

Structure
REQ-030 The req_lite_t/resp_lite_t typedefs SHALL come from ariane_axi_soc; the RESP_OKAY/RESP_SLVERR constants SHALL come from axi_pkg. No new package.
REQ-031 Address decode and error classification SHALL sit in one sub-module, cfg_lite_regbank_decode (combinational: index, in-range, ro, locked).

Verification
REQ-032 Base 0x1040_0000: write 0x1040_0008 data 0xDEADBEEF strb 0xF -> OKAY one cycle later, reg_wr_o[2] pulse, reg_q_o[2]=0xDEADBEEF.
REQ-033 Write strb 0x2 data 0x0000_5500 to reg 2 (holding 0xDEADBEEF) -> reg 2 = 0xDEAD55EF.
REQ-034 AW+W and AR to 0x1040_0004 in the same cycle -> write accepted first, read accepted after B handshake, read returns the new value.
REQ-035 Read 0x1040_0020 (NumRegs=8), and read 0x103F_FFFC -> both SLVERR with r_data 0; b_ready held low 5 cycles -> b_valid and b_resp stable throughout.
REQ-036 ReadOnlyMask bit 1 set, hw_d_i[1]=0x1234: write reg 1 -> SLVERR; read reg 1 -> 0x1234.
REQ-037 CFG_REGBANK_LOCK_EN: write 1 to reg 7, then write reg 0 -> SLVERR, reg 0 unchanged; write 0 to reg 7 -> lock remains set; rst_ni pulse -> lock clear.
